// File: rtl/mmio_link_reg.sv
// Snoops CPU data-memory accesses to one watched word: mirrors it, answers reads, and counts writes.
// Responses, pulses and the mirror update appear one cycle after the access; there is no backpressure.
module mmio_link_reg #(
  parameter logic [31:0] WATCH_ADDR  = 32'h0000_0040,
  parameter int          STALE_LIMIT = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_mem_link,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_update,
  output logic        o_err,
  output logic [15:0] o_write_cnt,
  output logic        o_stale
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALE  = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT_M1 = 16'(STALE_LIMIT - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [31:0] link_nxt;

  logic addr_hit;
  logic word_match;
  logic write_hit;
  logic read_hit;
  logic misaligned;

  assign addr_hit   = (i_addr == WATCH_ADDR);
  assign word_match = (i_addr[31:2] == WATCH_ADDR[31:2]);
  assign write_hit  = i_we && addr_hit && (i_be != 4'b0000);
  assign read_hit   = i_re && addr_hit;
  assign misaligned = word_match && (i_addr[1:0] != 2'b00) && (i_we || i_re);

  always_comb begin
    link_nxt = o_mem_link;
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) begin
        link_nxt[8*k +: 8] = i_wdata[8*k +: 8];
      end
    end
  end

  // Data path: mirror, read-back and pulses. Read samples the pre-write mirror.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_link  <= 32'h0;
      o_rdata     <= 32'h0;
      o_rvalid    <= 1'b0;
      o_update    <= 1'b0;
      o_err       <= 1'b0;
      o_write_cnt <= 16'h0;
    end else begin
      o_rvalid <= read_hit;
      o_update <= write_hit;
      o_err    <= misaligned;
      if (read_hit) begin
        o_rdata <= o_mem_link;
      end
      if (write_hit) begin
        o_mem_link <= link_nxt;
        if (o_write_cnt != 16'hFFFF) begin
          o_write_cnt <= o_write_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      timer <= 16'h0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // A write hit always wins over the timer reaching its limit.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (write_hit) begin
          state_nxt = ACTIVE;
          timer_nxt = 16'h0;
        end
      end
      ACTIVE: begin
        if (write_hit) begin
          timer_nxt = 16'h0;
        end else if (timer == LIMIT_M1) begin
          state_nxt = STALE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      STALE: begin
        if (write_hit) begin
          state_nxt = ACTIVE;
          timer_nxt = 16'h0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 16'h0;
      end
    endcase
  end

  always_comb begin
    o_stale = (state == STALE);
  end

endmodule

// File: tb/tb_mmio_link_reg.sv
// Directed bench for mmio_link_reg with hand-computed expectations.
module tb_mmio_link_reg;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] mem_link;
  logic [31:0] rdata;
  logic        rvalid;
  logic        update;
  logic        err;
  logic [15:0] write_cnt;
  logic        stale;

  int checks = 0;
  int errors = 0;

  mmio_link_reg #(
    .WATCH_ADDR (32'h0000_0040),
    .STALE_LIMIT(32)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_we       (we),
    .i_re       (re),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_be       (be),
    .o_mem_link (mem_link),
    .o_rdata    (rdata),
    .o_rvalid   (rvalid),
    .o_update   (update),
    .o_err      (err),
    .o_write_cnt(write_cnt),
    .o_stale    (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    we = w; re = r; addr = a; wdata = d; be = b;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b0, a, d, b);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
    tick();
    tick();
    chk("rst_link", mem_link, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_update", {31'h0, update}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_cnt", {16'h0, write_cnt}, 32'h0);
    chk("rst_stale", {31'h0, stale}, 32'h0);

    rst_n = 1'b1;
    idle(40);
    chk("idle_no_stale", {31'h0, stale}, 32'h0);

    wr(32'h40, 32'h0101_C000, 4'hF);
    chk("w1_link", mem_link, 32'h0101_C000);
    chk("w1_update", {31'h0, update}, 32'h1);
    chk("w1_cnt", {16'h0, write_cnt}, 32'd1);
    idle(1);
    chk("w1_update_drop", {31'h0, update}, 32'h0);

    wr(32'h40, 32'h1122_3344, 4'hF);
    wr(32'h40, 32'hAABB_CCDD, 4'b0101);
    chk("be5_link", mem_link, 32'h11BB_33DD);
    chk("be5_cnt", {16'h0, write_cnt}, 32'd3);
    wr(32'h40, 32'hFFFF_FFFF, 4'h0);
    chk("be0_link", mem_link, 32'h11BB_33DD);
    chk("be0_update", {31'h0, update}, 32'h0);
    chk("be0_cnt", {16'h0, write_cnt}, 32'd3);

    wr(32'h40, 32'h4, 4'hF);
    drive(1'b1, 1'b1, 32'h40, 32'h5, 4'hF);
    tick();
    chk("rw_rdata", rdata, 32'h4);
    chk("rw_rvalid", {31'h0, rvalid}, 32'h1);
    chk("rw_link", mem_link, 32'h5);
    chk("rw_cnt", {16'h0, write_cnt}, 32'd5);
    idle(1);
    chk("rv_drop", {31'h0, rvalid}, 32'h0);
    chk("rdata_hold", rdata, 32'h4);

    wr(32'h42, 32'hDEAD_BEEF, 4'hF);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_link", mem_link, 32'h5);
    chk("mis_cnt", {16'h0, write_cnt}, 32'd5);
    chk("mis_update", {31'h0, update}, 32'h0);
    drive(1'b0, 1'b1, 32'h41, 32'h0, 4'h0);
    tick();
    chk("misrd_err", {31'h0, err}, 32'h1);
    chk("misrd_rvalid", {31'h0, rvalid}, 32'h0);
    idle(1);
    chk("err_drop", {31'h0, err}, 32'h0);

    wr(32'h44, 32'h1234_5678, 4'hF);
    chk("other_link", mem_link, 32'h5);
    chk("other_err", {31'h0, err}, 32'h0);
    chk("other_cnt", {16'h0, write_cnt}, 32'd5);

    drive(1'b1, 1'b0, 32'h40, 32'h10, 4'hF);
    tick();
    chk("b2b_upd1", {31'h0, update}, 32'h1);
    drive(1'b1, 1'b0, 32'h40, 32'h20, 4'hF);
    tick();
    chk("b2b_upd2", {31'h0, update}, 32'h1);
    chk("b2b_link", mem_link, 32'h20);
    chk("b2b_cnt", {16'h0, write_cnt}, 32'd7);

    wr(32'h40, 32'h30, 4'hF);
    idle(31);
    chk("stale_31", {31'h0, stale}, 32'h0);
    idle(1);
    chk("stale_32", {31'h0, stale}, 32'h1);
    idle(5);
    chk("stale_hold", {31'h0, stale}, 32'h1);
    wr(32'h40, 32'h31, 4'hF);
    chk("stale_clear", {31'h0, stale}, 32'h0);
    idle(31);
    wr(32'h40, 32'h32, 4'hF);
    chk("hit_on_limit", {31'h0, stale}, 32'h0);
    idle(31);
    chk("rearm_31", {31'h0, stale}, 32'h0);
    idle(1);
    chk("rearm_32", {31'h0, stale}, 32'h1);
    chk("stale_cnt", {16'h0, write_cnt}, 32'd10);

    drive(1'b1, 1'b0, 32'h40, 32'h77, 4'hF);
    for (int i = 0; i < 65525; i++) tick();
    chk("sat_reach", {16'h0, write_cnt}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'h0, write_cnt}, 32'h0000_FFFF);

    for (int i = 0; i < 16; i++) begin
      if (i % 8 == 0) drive(1'b1, 1'b0, 32'h40, 32'hA5A5_0000 | i, 4'hF);
      else drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (i == 8) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("mid_link", mem_link, 32'h0);
    chk("mid_cnt", {16'h0, write_cnt}, 32'h0);
    chk("mid_update", {31'h0, update}, 32'h0);
    idle(40);
    chk("mid_idle_stale", {31'h0, stale}, 32'h0);
    wr(32'h40, 32'h99, 4'hF);
    chk("post_cnt", {16'h0, write_cnt}, 32'd1);
    idle(31);
    chk("post_31", {31'h0, stale}, 32'h0);
    idle(1);
    chk("post_32", {31'h0, stale}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
